// File: rtl/demux_1_4_tdm_if.sv
// Bundle of the serial-in / 4-lane-out handshake signals of demux_1_4_tdm.
// Latency: none (wires only).
// Backpressure: in_ready/in_valid on the serial side, out_valid/out_ready on the frame side.
// Ports: in_valid, in_data, in_ready (serial lane); out_valid, out_ready, d0..d3 (frame);
//        slot (next slot to fill); in_sof, sync_err only when DEMUX_SOF_EN is defined.
interface demux_1_4_tdm_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic [1:0]   slot;
`ifdef DEMUX_SOF_EN
  logic         in_sof;
  logic         sync_err;
`endif

  // master drives the serial lane and consumes frames; slave is the demux
  modport master (
    output in_valid, in_data, out_ready,
`ifdef DEMUX_SOF_EN
    output in_sof,
    input  sync_err,
`endif
    input  in_ready, out_valid, d0, d1, d2, d3, slot
  );

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef DEMUX_SOF_EN
    input  in_sof,
    output sync_err,
`endif
    output in_ready, out_valid, d0, d1, d2, d3, slot
  );
endinterface

// File: rtl/demux_1_4_tdm.sv
// 1:4 time-division demux: round-robin serial words into a registered 4-lane frame.
// Latency: frame valid 1 cycle after its 4th word is accepted.
// Backpressure: only the slot-3 word stalls, and only while a held frame is not being taken.
// Ports: clk, rst (async, active-high); bus (demux_1_4_tdm_if.slave) carrying
//        in_valid/in_data/in_ready, out_valid/out_ready, d0..d3, slot.
// Optional: DEMUX_SOF_EN adds in_sof (realign to slot 0) and sticky sync_err.
module demux_1_4_tdm #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  demux_1_4_tdm_if.slave bus
);

  logic [1:0]   slot_q;
  logic [W-1:0] asm0_q, asm1_q, asm2_q;
  logic [W-1:0] d0_q, d1_q, d2_q, d3_q;
  logic         out_valid_q;
  logic         sof;
  logic         accept;
  logic         commit;

`ifdef DEMUX_SOF_EN
  logic sync_err_q;
  assign sof          = bus.in_sof;
  assign bus.sync_err = sync_err_q;
`else
  assign sof = 1'b0;
`endif

  // Slots 0..2 only fill assembly registers, so they never need to wait.
  assign bus.in_ready = (slot_q != 2'd3) || !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  // A start-of-frame word realigns instead of completing a frame.
  assign commit       = accept && (slot_q == 2'd3) && !sof;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= 2'd0;
      asm0_q      <= '0;
      asm1_q      <= '0;
      asm2_q      <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      out_valid_q <= 1'b0;
`ifdef DEMUX_SOF_EN
      sync_err_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        if (sof) begin
          asm0_q <= bus.in_data;
          slot_q <= 2'd1;
`ifdef DEMUX_SOF_EN
          if (slot_q != 2'd0) sync_err_q <= 1'b1;
`endif
        end else begin
          case (slot_q)
            2'd0: asm0_q <= bus.in_data;
            2'd1: asm1_q <= bus.in_data;
            2'd2: asm2_q <= bus.in_data;
            default: begin
              // last word bypasses assembly so the frame is ready one edge later
              d0_q <= asm0_q;
              d1_q <= asm1_q;
              d2_q <= asm2_q;
              d3_q <= bus.in_data;
            end
          endcase
          slot_q <= slot_q + 2'd1;
        end
      end

      // commit wins over release so back-to-back frames have no bubble
      if (commit)             out_valid_q <= 1'b1;
      else if (bus.out_ready) out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.d0        = d0_q;
  assign bus.d1        = d1_q;
  assign bus.d2        = d2_q;
  assign bus.d3        = d3_q;
  assign bus.slot      = slot_q;

endmodule
